// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
// The line macro expands inside a module once the tag/data widths are known.
`ifndef DCACHE_PKG_SV
`define DCACHE_PKG_SV

`define DECLARE_DCACHE_LINE(tag_w, data_w) \
  typedef struct packed { \
    logic                valid; \
    logic                dirty; \
    logic [(tag_w)-1:0]  tag; \
    logic [(data_w)-1:0] data; \
  } dcache_line_t;

package dcache_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dcache_state_e;

  function automatic int unsigned set_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned aw, input int unsigned sets);
    return aw - $clog2(sets);
  endfunction

  // a single way still needs a 1-bit index so the pointer array stays well formed
  function automatic int unsigned way_bits(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

`endif

// File: rtl/dcache_replace.sv
// Per-set round-robin victim pointer; cleared by the init walk, advanced on
// replacement of an occupied way.
module dcache_replace
  import dcache_pkg::*;
#(
  parameter int unsigned sets = 32,
  parameter int unsigned ways = 2
) (
  input  logic                         clk_i,
  input  logic                         clear_i,
  input  logic [set_bits(sets)-1:0]    clear_set_i,
  input  logic                         adv_i,
  input  logic [set_bits(sets)-1:0]    set_i,
  output logic [way_bits(ways)-1:0]    ptr_c
);

  localparam int unsigned WB = way_bits(ways);

  logic [WB-1:0] ptr_q [sets];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      ptr_q[clear_set_i] <= '0;
    end else if (adv_i) begin
      ptr_q[set_i] <= (ptr_q[set_i] == WB'(ways - 1)) ? '0 : ptr_q[set_i] + WB'(1);
    end
  end

  assign ptr_c = ptr_q[set_i];

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back data cache array: 1-cycle lookup, 1-cycle
// write/allocate with dirty-victim ejection, and a set-by-set init walk.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int unsigned addr_width = 16,
  parameter int unsigned line_width = 64,
  parameter int unsigned sets       = 32,
  parameter int unsigned ways       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  ready_o,
  input  logic [addr_width-1:0] addr_i,
  input  logic                  r_valid_i,
  output logic                  r_valid_o,
  output logic                  r_miss_o,
  output logic [line_width-1:0] read_o,
  input  logic                  w_valid_i,
  input  logic                  dirty_i,
  input  logic [line_width-1:0] write_i,
  output logic                  ejected_valid_o,
  output logic [addr_width-1:0] ejected_addr_o,
  output logic [line_width-1:0] ejected_o
);

  localparam int unsigned SB = set_bits(sets);
  localparam int unsigned TB = tag_bits(addr_width, sets);
  localparam int unsigned WB = way_bits(ways);

  `DECLARE_DCACHE_LINE(TB, line_width)

  dcache_state_e state_q, state_n;
  logic [SB-1:0] clr_cnt_q, clr_cnt_n;
  logic          clear_c;

  dcache_line_t  lines_q [sets][ways];

  logic [SB-1:0] set_c;
  logic [TB-1:0] tag_c;
  logic          hit_c, inv_c, acc_r_c, acc_w_c, ej_c;
  logic [WB-1:0] hit_way_c, inv_way_c, rr_way_c, vic_way_c;
  dcache_line_t  vic_c;

  assign set_c = addr_i[SB-1:0];
  assign tag_c = addr_i[addr_width-1:SB];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      clr_cnt_q <= clr_cnt_n;
    end
  end

  // Init walk: one set per cycle, then idle
  always_comb begin
    state_n   = state_q;
    clr_cnt_n = clr_cnt_q;
    clear_c   = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_c   = 1'b1;
        clr_cnt_n = clr_cnt_q + SB'(1);
        if (clr_cnt_q == SB'(sets - 1)) begin
          state_n   = IDLE;
          clr_cnt_n = '0;
        end
      end
      IDLE:    state_n = IDLE;
      default: state_n = CLEAR;
    endcase
  end

  assign acc_r_c = r_valid_i && (state_q == IDLE) && !rst_i;
  assign acc_w_c = w_valid_i && (state_q == IDLE) && !rst_i;

  // Parallel tag compare; descending scan leaves the lowest-index match/free way
  always_comb begin
    hit_c     = 1'b0;
    inv_c     = 1'b0;
    hit_way_c = '0;
    inv_way_c = '0;
    for (int w = int'(ways) - 1; w >= 0; w--) begin
      if (lines_q[set_c][w].valid && (lines_q[set_c][w].tag == tag_c)) begin
        hit_c     = 1'b1;
        hit_way_c = WB'(w);
      end
      if (!lines_q[set_c][w].valid) begin
        inv_c     = 1'b1;
        inv_way_c = WB'(w);
      end
    end
    vic_way_c = hit_c ? hit_way_c : (inv_c ? inv_way_c : rr_way_c);
    vic_c     = lines_q[set_c][vic_way_c];
  end

  assign ej_c = acc_w_c && !hit_c && vic_c.valid && vic_c.dirty;

  dcache_replace #(
    .sets (sets),
    .ways (ways)
  ) u_replace (
    .clk_i       (clk_i),
    .clear_i     (clear_c),
    .clear_set_i (clr_cnt_q),
    .adv_i       (acc_w_c && !hit_c && !inv_c),
    .set_i       (set_c),
    .ptr_c       (rr_way_c)
  );

  // Line storage; on a hit the victim is the hit line, so vic_c.dirty is the old dirty bit
  always_ff @(posedge clk_i) begin
    if (clear_c) begin
      for (int w = 0; w < int'(ways); w++) begin
        lines_q[clr_cnt_q][w].valid <= 1'b0;
        lines_q[clr_cnt_q][w].dirty <= 1'b0;
      end
    end else if (acc_w_c) begin
      if (hit_c) begin
        lines_q[set_c][hit_way_c].data  <= write_i;
        lines_q[set_c][hit_way_c].dirty <= vic_c.dirty | dirty_i;
      end else begin
        lines_q[set_c][vic_way_c] <= '{valid: 1'b1, dirty: dirty_i, tag: tag_c, data: write_i};
      end
    end
  end

  // Registered read results and ejection pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_o         <= 1'b0;
      r_valid_o       <= 1'b0;
      r_miss_o        <= 1'b0;
      read_o          <= '0;
      ejected_valid_o <= 1'b0;
      ejected_addr_o  <= '0;
      ejected_o       <= '0;
    end else begin
      ready_o         <= (state_n == IDLE);
      r_valid_o       <= acc_r_c;
      r_miss_o        <= acc_r_c && !hit_c;
      read_o          <= (acc_r_c && hit_c) ? vic_c.data : '0;
      ejected_valid_o <= ej_c;
      ejected_addr_o  <= ej_c ? {vic_c.tag, set_c} : '0;
      ejected_o       <= ej_c ? vic_c.data : '0;
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (8-bit addresses, 16-bit lines, 4 sets x 2 ways).
module tb_dcache_assoc;

  logic        clk_i;
  logic        rst_i;
  logic        ready_o;
  logic [7:0]  addr_i;
  logic        r_valid_i;
  logic        r_valid_o;
  logic        r_miss_o;
  logic [15:0] read_o;
  logic        w_valid_i;
  logic        dirty_i;
  logic [15:0] write_i;
  logic        ejected_valid_o;
  logic [7:0]  ejected_addr_o;
  logic [15:0] ejected_o;

  int tests = 0;
  int failed = 0;

  dcache_assoc #(
    .addr_width (8),
    .line_width (16),
    .sets       (4),
    .ways       (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ready_o         (ready_o),
    .addr_i          (addr_i),
    .r_valid_i       (r_valid_i),
    .r_valid_o       (r_valid_o),
    .r_miss_o        (r_miss_o),
    .read_o          (read_o),
    .w_valid_i       (w_valid_i),
    .dirty_i         (dirty_i),
    .write_i         (write_i),
    .ejected_valid_o (ejected_valid_o),
    .ejected_addr_o  (ejected_addr_o),
    .ejected_o       (ejected_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One request cycle; returns 1 ns after the edge that registers the result
  task automatic op(input logic rd, input logic wr, input logic [7:0] a,
                    input logic d, input logic [15:0] data);
    r_valid_i = rd;
    w_valid_i = wr;
    addr_i    = a;
    dirty_i   = d;
    write_i   = data;
    @(posedge clk_i);
    #1;
    r_valid_i = 1'b0;
    w_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (4) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tests++;
    if (r_valid_o !== 1'b0 || ejected_valid_o !== 1'b0 || read_o !== 16'h0) begin
      failed++;
      $display("FAIL reset_outputs: r_valid=%b ej_valid=%b read=%h, need 0 0 0000",
               r_valid_o, ejected_valid_o, read_o);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (ready_o !== 1'b0) begin
        failed++;
        $display("FAIL reset_ready_low[%0d]: ready=%b, need 0", i, ready_o);
      end
      @(posedge clk_i);
      #1;
    end
    tests++;
    if (ready_o !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready_high: ready=%b, need 1", ready_o);
    end
    op(1'b1, 1'b0, 8'h00, 1'b0, 16'h0);
    tests++;
    if (r_valid_o !== 1'b1 || r_miss_o !== 1'b1 || read_o !== 16'h0) begin
      failed++;
      $display("FAIL reset_read_miss: valid=%b miss=%b data=%h, need 1 1 0000",
               r_valid_o, r_miss_o, read_o);
    end
  endtask

  task automatic test_write_read();
    op(1'b0, 1'b1, 8'h05, 1'b0, 16'hBEEF);
    tests++;
    if (ejected_valid_o !== 1'b0 || r_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL wr_first: ej_valid=%b r_valid=%b, need 0 0", ejected_valid_o, r_valid_o);
    end
    op(1'b1, 1'b0, 8'h05, 1'b0, 16'h0);
    tests++;
    if (r_valid_o !== 1'b1 || r_miss_o !== 1'b0 || read_o !== 16'hBEEF) begin
      failed++;
      $display("FAIL wr_read_hit: valid=%b miss=%b data=%h, need 1 0 beef",
               r_valid_o, r_miss_o, read_o);
    end
  endtask

  task automatic test_dirty_evict();
    do_reset();
    op(1'b0, 1'b1, 8'h01, 1'b1, 16'h1111);
    op(1'b0, 1'b1, 8'h05, 1'b1, 16'h2222);
    tests++;
    if (ejected_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL dirty_fill_no_ej: ej_valid=%b, need 0", ejected_valid_o);
    end
    op(1'b0, 1'b1, 8'h09, 1'b1, 16'h3333);
    tests++;
    if (ejected_valid_o !== 1'b1 || ejected_addr_o !== 8'h01 || ejected_o !== 16'h1111) begin
      failed++;
      $display("FAIL dirty_evict: ej=%b addr=%h data=%h, need 1 01 1111",
               ejected_valid_o, ejected_addr_o, ejected_o);
    end
    op(1'b1, 1'b0, 8'h09, 1'b0, 16'h0);
    tests++;
    if (ejected_valid_o !== 1'b0 || r_miss_o !== 1'b0 || read_o !== 16'h3333) begin
      failed++;
      $display("FAIL evict_pulse_read: ej=%b miss=%b data=%h, need 0 0 3333",
               ejected_valid_o, r_miss_o, read_o);
    end
    // round-robin pointer now selects way 1, which holds 0x05
    op(1'b0, 1'b1, 8'h0D, 1'b1, 16'h4444);
    tests++;
    if (ejected_valid_o !== 1'b1 || ejected_addr_o !== 8'h05 || ejected_o !== 16'h2222) begin
      failed++;
      $display("FAIL rr_evict: ej=%b addr=%h data=%h, need 1 05 2222",
               ejected_valid_o, ejected_addr_o, ejected_o);
    end
    op(1'b1, 1'b0, 8'h01, 1'b0, 16'h0);
    tests++;
    if (r_valid_o !== 1'b1 || r_miss_o !== 1'b1) begin
      failed++;
      $display("FAIL evicted_miss: valid=%b miss=%b, need 1 1", r_valid_o, r_miss_o);
    end
  endtask

  task automatic test_clean_evict();
    op(1'b0, 1'b1, 8'h02, 1'b0, 16'hAAAA);
    op(1'b0, 1'b1, 8'h06, 1'b0, 16'hBBBB);
    op(1'b0, 1'b1, 8'h0A, 1'b0, 16'hCCCC);
    tests++;
    if (ejected_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL clean_no_ej: ej_valid=%b, need 0", ejected_valid_o);
    end
    op(1'b1, 1'b0, 8'h02, 1'b0, 16'h0);
    tests++;
    if (r_valid_o !== 1'b1 || r_miss_o !== 1'b1 || read_o !== 16'h0) begin
      failed++;
      $display("FAIL clean_victim_miss: valid=%b miss=%b data=%h, need 1 1 0000",
               r_valid_o, r_miss_o, read_o);
    end
    op(1'b1, 1'b0, 8'h06, 1'b0, 16'h0);
    tests++;
    if (r_miss_o !== 1'b0 || read_o !== 16'hBBBB) begin
      failed++;
      $display("FAIL clean_keep_hit: miss=%b data=%h, need 0 bbbb", r_miss_o, read_o);
    end
    op(1'b1, 1'b0, 8'h0A, 1'b0, 16'h0);
    tests++;
    if (r_miss_o !== 1'b0 || read_o !== 16'hCCCC) begin
      failed++;
      $display("FAIL clean_new_hit: miss=%b data=%h, need 0 cccc", r_miss_o, read_o);
    end
  endtask

  task automatic test_dirty_merge();
    op(1'b0, 1'b1, 8'h03, 1'b1, 16'h1111);
    op(1'b0, 1'b1, 8'h03, 1'b0, 16'h1234);
    op(1'b0, 1'b1, 8'h07, 1'b0, 16'h7777);
    tests++;
    if (ejected_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL merge_fill_no_ej: ej_valid=%b, need 0", ejected_valid_o);
    end
    op(1'b0, 1'b1, 8'h0B, 1'b0, 16'hBBBB);
    tests++;
    if (ejected_valid_o !== 1'b1 || ejected_addr_o !== 8'h03 || ejected_o !== 16'h1234) begin
      failed++;
      $display("FAIL merge_evict: ej=%b addr=%h data=%h, need 1 03 1234",
               ejected_valid_o, ejected_addr_o, ejected_o);
    end
  endtask

  task automatic test_back_to_back();
    op(1'b0, 1'b1, 8'h10, 1'b1, 16'hA5A5);
    op(1'b1, 1'b1, 8'h10, 1'b0, 16'h5A5A);
    tests++;
    if (r_valid_o !== 1'b1 || r_miss_o !== 1'b0 || read_o !== 16'hA5A5) begin
      failed++;
      $display("FAIL b2b_read_pre_write: valid=%b miss=%b data=%h, need 1 0 a5a5",
               r_valid_o, r_miss_o, read_o);
    end
    op(1'b1, 1'b0, 8'h10, 1'b0, 16'h0);
    tests++;
    if (r_miss_o !== 1'b0 || read_o !== 16'h5A5A || ejected_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL b2b_read_new: miss=%b data=%h ej=%b, need 0 5a5a 0",
               r_miss_o, read_o, ejected_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] prior [9];
    prior = '{8'h05, 8'h09, 8'h0D, 8'h06, 8'h0A, 8'h03, 8'h07, 8'h0B, 8'h10};
    rst_i     = 1'b1;
    r_valid_i = 1'b1;
    addr_i    = 8'h06;
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    w_valid_i = 1'b1;
    addr_i    = 8'h20;
    dirty_i   = 1'b1;
    write_i   = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (ready_o !== 1'b0 || r_valid_o !== 1'b0 || ejected_valid_o !== 1'b0) begin
        failed++;
        $display("FAIL mid_reset_ignore[%0d]: ready=%b r_valid=%b ej=%b, need 0 0 0",
                 i, ready_o, r_valid_o, ejected_valid_o);
      end
      @(posedge clk_i);
      #1;
    end
    r_valid_i = 1'b0;
    w_valid_i = 1'b0;
    tests++;
    if (ready_o !== 1'b1) begin
      failed++;
      $display("FAIL mid_reset_ready: ready=%b, need 1", ready_o);
    end
    for (int i = 0; i < 9; i++) begin
      op(1'b1, 1'b0, prior[i], 1'b0, 16'h0);
      tests++;
      if (r_valid_o !== 1'b1 || r_miss_o !== 1'b1) begin
        failed++;
        $display("FAIL mid_reset_miss[%h]: valid=%b miss=%b, need 1 1",
                 prior[i], r_valid_o, r_miss_o);
      end
    end
    op(1'b1, 1'b0, 8'h20, 1'b0, 16'h0);
    tests++;
    if (r_miss_o !== 1'b1) begin
      failed++;
      $display("FAIL clear_write_ignored: miss=%b, need 1", r_miss_o);
    end
  endtask

  initial begin
    rst_i     = 1'b1;
    addr_i    = '0;
    r_valid_i = 1'b0;
    w_valid_i = 1'b0;
    dirty_i   = 1'b0;
    write_i   = '0;
    test_reset();
    test_write_read();
    test_dirty_evict();
    test_clean_evict();
    test_dirty_merge();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
